// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol mapper: mode encoding, normalisation
// factors and the constant function that turns a constellation level into a
// fixed-point amplitude for a given component width.
package qam_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_QAM16 = 2'd2,
        MODE_QAM64 = 2'd3
    } qam_mode_e;

    // Normalisation factors Kmod as unsigned Q0.30 fractions:
    // 1, 1/sqrt(2), 1/sqrt(10), 1/sqrt(42).
    localparam int    KMOD_FRAC      = 30;
    localparam longint KMOD_Q30_BPSK  = 64'sd1073741824;
    localparam longint KMOD_Q30_QPSK  = 64'sd759250125;
    localparam longint KMOD_Q30_QAM16 = 64'sd339546978;
    localparam longint KMOD_Q30_QAM64 = 64'sd165681960;

    // round(l * Kmod * 2^(w-2)) for a positive level l; negative levels are
    // produced by negating this value, so the constellation stays symmetric.
    function automatic int level_value(qam_mode_e mode, int l, int w);
        longint k;
        longint p;
        case (mode)
            MODE_BPSK:  k = KMOD_Q30_BPSK;
            MODE_QPSK:  k = KMOD_Q30_QPSK;
            MODE_QAM16: k = KMOD_Q30_QAM16;
            default:    k = KMOD_Q30_QAM64;
        endcase
        p = longint'(l) * k;
        p = p <<< (w - 2);
        p = p + (64'sd1 <<< (KMOD_FRAC - 1));
        return int'(p >>> KMOD_FRAC);
    endfunction

endpackage

// File: rtl/qam_lut.sv
// Purely combinational Gray-coded constellation map: {bits, mode} -> {Im, Re}.
// Both axes share the same structure, so one generate iteration builds each.
module qam_lut
    import qam_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [5:0]     bits,
    input  qam_mode_e      mode,
    output logic [2*W-1:0] sym
);

    localparam logic [W-1:0] A_BPSK  = W'(level_value(MODE_BPSK, 1, W));
    localparam logic [W-1:0] A_QPSK  = W'(level_value(MODE_QPSK, 1, W));
    localparam logic [W-1:0] A16_1   = W'(level_value(MODE_QAM16, 1, W));
    localparam logic [W-1:0] A16_3   = W'(level_value(MODE_QAM16, 3, W));
    localparam logic [W-1:0] A64_1   = W'(level_value(MODE_QAM64, 1, W));
    localparam logic [W-1:0] A64_3   = W'(level_value(MODE_QAM64, 3, W));
    localparam logic [W-1:0] A64_5   = W'(level_value(MODE_QAM64, 5, W));
    localparam logic [W-1:0] A64_7   = W'(level_value(MODE_QAM64, 7, W));

    // gi = 0 builds Re (I), gi = 1 builds Im (Q).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            logic [W-1:0] mag;
            logic         neg;
            logic [W-1:0] axis;

            // First bit of each axis group selects the sign, the rest pick
            // the magnitude in Gray order.
            always_comb begin
                mag = '0;
                neg = 1'b0;
                case (mode)
                    MODE_BPSK: begin
                        if (gi == 0) begin
                            mag = A_BPSK;
                            neg = ~bits[0];
                        end
                    end
                    MODE_QPSK: begin
                        mag = A_QPSK;
                        neg = ~bits[gi];
                    end
                    MODE_QAM16: begin
                        neg = ~bits[2*gi];
                        mag = bits[2*gi+1] ? A16_1 : A16_3;
                    end
                    default: begin
                        neg = ~bits[3*gi];
                        case ({bits[3*gi+1], bits[3*gi+2]})
                            2'b00:   mag = A64_7;
                            2'b01:   mag = A64_5;
                            2'b11:   mag = A64_3;
                            default: mag = A64_1;
                        endcase
                    end
                endcase
                axis = neg ? (W'(0) - mag) : mag;
            end

            assign sym[gi*W +: W] = axis;
        end
    endgenerate

endmodule

// File: rtl/qam_mapper.sv
// QAM symbol mapper with bus-style handshakes on both sides. Symbols are
// mapped on entry and queued in a small inline FIFO; the frame mode is
// latched when a bus cycle opens and held until the frame has fully drained.
module qam_mapper
    import qam_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic           CLK_I,
    input  logic           RST_I,
    input  logic [5:0]     DAT_I,
    input  logic [1:0]     MODE_I,
    input  logic           CYC_I,
    input  logic           STB_I,
    input  logic           WE_I,
    output logic           ACK_O,
    output logic [2*W-1:0] DAT_O,
    output logic           CYC_O,
    output logic           STB_O,
    output logic           WE_O,
    input  logic           ACK_I
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]     state_reg, state_next;
    qam_mode_e      mode_reg;
    qam_mode_e      mode_use;
    logic [CW-1:0]  count_reg;
    logic [AW-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic           cyc_reg;
    logic [2*W-1:0] mem [DEPTH];
    logic [2*W-1:0] sym;

    logic ena, stb, pop, push;

    assign ena  = CYC_I & STB_I & WE_I;
    assign stb  = (count_reg != '0);
    assign pop  = stb & ACK_I;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push = ena & ~RST_I & ((count_reg < CW'(DEPTH)) | pop);

    // The opening cycle of a frame maps with MODE_I directly; later symbols
    // use the latched value.
    assign mode_use = (state_reg == ST_IDLE) ? qam_mode_e'(MODE_I) : mode_reg;

    qam_lut #(.W(W)) u_lut (
        .bits (DAT_I),
        .mode (mode_use),
        .sym  (sym)
    );

    // Frame tracking: open on CYC_I, drain after CYC_I drops, close when empty.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (CYC_I) state_next = ST_ACTIVE;
            ST_ACTIVE: if (!CYC_I) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if ((count_reg == '0) && !push) state_next = ST_IDLE;
                else if (CYC_I)                 state_next = ST_ACTIVE;
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // Control state: FSM, latched mode, FIFO pointers/occupancy, CYC_O.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_reg  <= ST_IDLE;
            mode_reg   <= MODE_BPSK;
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            cyc_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && CYC_I) begin
                mode_reg <= qam_mode_e'(MODE_I);
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            cyc_reg <= (state_next != ST_IDLE);
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem[wr_ptr_reg] <= sym;
        end
    end

    assign ACK_O = push;
    assign STB_O = stb;
    assign WE_O  = stb;
    assign CYC_O = cyc_reg;
    assign DAT_O = stb ? mem[rd_ptr_reg] : '0;

endmodule
